rank_filter: RTL and testbench
==============================

# rank_filter

Parametrised rank-order filter for the image-processing datapath: accepts a window of `N` unsigned samples through a valid/ready handshake and sorts it in place with a sequential odd-even transposition network. It returns the median, minimum, maximum or an arbitrary rank, selected per window. It replaces the fixed 3x3, 8-bit median stage with configurable width and window size, an output handshake with backpressure, and optional early termination.

## Interface
- `DATA_W`, default 8: sample width in bits, range 2..16.
- `N`, default 9: window size, odd, range 3..25.
- `EARLY_EXIT`, default 1: when 1, sorting stops after two consecutive swap-free phases.
- `IDX_W`, default `$clog2(N)`: width of the rank index (derived).
- `clk_i`  in  1: clock; all state changes on its rising edge.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `in_valid_i`  in  1: input window valid.
- `in_ready_o`  out  1: block can accept a window; equals (state==IDLE).
- `data_i`  in  `N*DATA_W`: packed window; sample k occupies bits `[k*DATA_W +: DATA_W]`.
- `mode_i`  in  2: selection mode. 00 = median, 01 = min, 10 = max, 11 = rank.
- `rank_i`  in  `IDX_W`: rank for mode 11; 0 = smallest. Values ≥ N clamp to N-1.
- `out_valid_o`  out  1: result valid.
- `out_ready_i`  in  1: downstream accepts the result.
- `data_o`  out  `DATA_W`: selected value, registered.
- `busy_o`  out  1: high in SORT or DONE.

## Operation
- Unsigned comparison throughout. Ties need no special handling; equal values are interchangeable.
- FSM states: IDLE, SORT, DONE. Reset state is IDLE.
- **IDLE**
  - On the accept edge (`in_valid_i && in_ready_o`), all N samples are captured into the sample array.
  - The selection index `sel` is captured at the same edge: median → (N-1)/2, min → 0, max → N-1, rank → min(`rank_i`, N-1).
  - Phase counter `cnt` ← 0; zero-swap history flag cleared; state → SORT.
  - Inputs are ignored when no accept occurs.
- **SORT, while cnt < N:** one phase per cycle.
  - Even `cnt`: compare-swap pairs (0,1), (2,3), …, (N-3,N-2).
  - Odd `cnt`: compare-swap pairs (1,2), (3,4), …, (N-2,N-1).
  - Each swap places the smaller value at the lower index.
  - `cnt` increments after each phase.
- **Early exit (`EARLY_EXIT`=1):** if the current phase performs zero swaps and the previous phase also performed zero swaps, `cnt` ← N at that edge.
- **SORT, cnt == N:** next edge loads `data_o` ← array[`sel`], sets `out_valid_o` ← 1, state → DONE.
- **DONE:** `out_valid_o` and `data_o` are held stable until `out_ready_i`=1. On that edge `out_valid_o` ← 0 and state → IDLE. `data_o` keeps its last value.
- `mode_i` and `rank_i` are sampled only on the accept edge. Changes during SORT or DONE have no effect.
- No overlap: a new window is accepted only in IDLE.

## Timing
- Reset values: state IDLE, `out_valid_o`=0, `data_o`=0, `busy_o`=0, `in_ready_o`=1, sample array all zero, `cnt`=0.
- Reset is asynchronous. Asserting `rst_ni` mid-SORT or mid-DONE forces the reset values immediately and drops the window in flight.
- Latency, counted from the accept edge (edge 0) to the edge at which `out_valid_o` rises:
  - `EARLY_EXIT`=0: exactly N+1 edges.
  - `EARLY_EXIT`=1: between 3 and N+1 edges.
- Phases occupy edges 1..k; the output is loaded at edge k+1.
- Throughput: one window per (latency + 1 + output wait) cycles. Earliest re-accept is the edge after the output handshake.
- `in_ready_o` and `busy_o` are combinational from the state register; no combinational path from any input to any output.

## Test plan
- **Reversed window, median, no early exit.** N=9, `DATA_W`=8, `EARLY_EXIT`=0, window {9,8,7,6,5,4,3,2,1}, mode 00, `out_ready_i`=1.
  - `data_o`=5; `out_valid_o` rises exactly 10 edges after accept; `in_ready_o` returns to 1 one edge later.
- **Sorted window, early exit.** `EARLY_EXIT`=1, window {1..9} ascending, mode 00.
  - `data_o`=5; `out_valid_o` rises 3 edges after accept.
- **Mode sweep.** Window {200,3,3,255,0,17,17,17,90}.
  - Mode 01 → 0.
  - Mode 10 → 255.
  - Mode 11, rank 4 → 17.
  - Mode 11, rank 1 → 3.
  - Mode 11, rank 12 → 255 (clamped).
- **Backpressure.** Hold `out_ready_i`=0 for 6 cycles after `out_valid_o` rises, and drive `in_valid_i`=1 with a new window throughout.
  - `out_valid_o` stays 1, `data_o` stays stable, `in_ready_o` stays 0, and the new window is not captured.
  - Raise `out_ready_i`: the block returns to IDLE at the next edge and captures the pending window on the following edge.
- **Reset mid-operation.** Pull `rst_ni` low during SORT phase 4.
  - `busy_o`=0, `out_valid_o`=0, `data_o`=0 and `in_ready_o`=1 without waiting for a clock edge.
  - After release, window {5,5,5,5,5,5,5,5,4} in median mode gives 5.
- **Parameter corners.**
  - N=3, `DATA_W`=16, {0xFFFF,0x0000,0x8000}: median gives 0x8000.
  - N=25 with random windows against a reference sort, for all modes and 1000 windows, with random `out_ready_i` stalls.

Source files
------------

// File: rtl/rank_filter.sv
// rank_filter: rank-order filter. It accepts a window of N unsigned samples
// through a valid/ready handshake and sorts the window in place with a
// sequential odd-even transposition network, running one phase per cycle.
// It returns the median, minimum, maximum or a chosen rank of the window.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   in_valid_i          input window valid
//   in_ready_o          window can be accepted (state == IDLE)
//   data_i [N*DATA_W]   packed window, sample k at [k*DATA_W +: DATA_W]
//   mode_i [2]          00 median, 01 min, 10 max, 11 rank
//   rank_i [IDX_W]      rank for mode 11, 0 = smallest, clamped to N-1
//   out_valid_o         result valid, held until out_ready_i
//   out_ready_i         downstream accepts the result
//   data_o [DATA_W]     selected value, registered
//   busy_o              high in SORT or DONE
module rank_filter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned N          = 9,
  parameter int unsigned EARLY_EXIT = 1,
  parameter int unsigned IDX_W      = $clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N*DATA_W-1:0]   data_i,
  input  logic [1:0]            mode_i,
  input  logic [IDX_W-1:0]      rank_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  busy_o
);

  localparam int unsigned        CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0]   CNT_DONE = CNT_W'(N);
  localparam logic [IDX_W-1:0]   IDX_MAX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]   IDX_MED  = IDX_W'((N - 1) / 2);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   arr       [N];
  logic [DATA_W-1:0]   phase_arr [N];
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    sel_in;
  logic                prev_clean;
  logic                swap_any;

  assign in_ready_o = (state == IDLE);
  assign busy_o     = (state != IDLE);

  // Selection index derived from mode/rank at the accept edge.
  always_comb begin
    sel_in = IDX_MED;
    case (mode_i)
      2'b00:   sel_in = IDX_MED;
      2'b01:   sel_in = '0;
      2'b10:   sel_in = IDX_MAX;
      default: sel_in = (rank_i > IDX_MAX) ? IDX_MAX : rank_i;
    endcase
  end

  // One transposition phase: pairs start at even indices on even cnt and at
  // odd indices on odd cnt, so the pairs never overlap within a phase.
  always_comb begin
    phase_arr = arr;
    swap_any  = 1'b0;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if ((i[0] == cnt[0]) && (arr[i] > arr[i+1])) begin
        phase_arr[i]   = arr[i+1];
        phase_arr[i+1] = arr[i];
        swap_any       = 1'b1;
      end
    end
  end

  // Control FSM, sample array and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= '0;
      prev_clean  <= 1'b0;
      out_valid_o <= 1'b0;
      data_o      <= '0;
      for (int unsigned k = 0; k < N; k++) arr[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            for (int unsigned k = 0; k < N; k++) arr[k] <= data_i[k*DATA_W +: DATA_W];
            sel        <= sel_in;
            cnt        <= '0;
            prev_clean <= 1'b0;
            state      <= SORT;
          end
        end
        SORT: begin
          if (cnt == CNT_DONE) begin
            data_o      <= arr[sel];
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else begin
            arr        <= phase_arr;
            prev_clean <= !swap_any;
            // Two consecutive swap-free phases (one of each parity) mean sorted.
            if ((EARLY_EXIT != 0) && !swap_any && prev_clean) cnt <= CNT_DONE;
            else                                               cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rank_filter.sv
// tb_rank_filter: directed bench for rank_filter. It drives four instances:
// N=9 without early exit, N=9 with early exit, N=3 with 16-bit samples, and
// N=25 with random windows checked against a reference sort.
module tb_rank_filter;

  localparam int unsigned W8  = 8;
  localparam int unsigned N9  = 9;
  localparam int unsigned N25 = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Shared N=9 stimulus; a = no early exit, b = early exit
  logic                 in_valid_a, in_valid_b;
  logic [N9*W8-1:0]     data9;
  logic [1:0]           mode9;
  logic [3:0]           rank9;
  logic                 out_ready9;
  logic                 in_ready_a, out_valid_a, busy_a;
  logic                 in_ready_b, out_valid_b, busy_b;
  logic [7:0]           dout_a, dout_b;

  // N=3, 16-bit
  logic                 in_valid_c, in_ready_c, out_valid_c, out_ready_c, busy_c;
  logic [47:0]          data_c;
  logic [1:0]           mode_c;
  logic [1:0]           rank_c;
  logic [15:0]          dout_c;

  // N=25
  logic                 in_valid_d, in_ready_d, out_valid_d, out_ready_d, busy_d;
  logic [N25*W8-1:0]    data_d;
  logic [1:0]           mode_d;
  logic [4:0]           rank_d;
  logic [7:0]           dout_d;

  rank_filter #(.DATA_W(8), .N(9), .EARLY_EXIT(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
    .data_i(data9), .mode_i(mode9), .rank_i(rank9), .out_valid_o(out_valid_a),
    .out_ready_i(out_ready9), .data_o(dout_a), .busy_o(busy_a));

  rank_filter #(.DATA_W(8), .N(9), .EARLY_EXIT(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
    .data_i(data9), .mode_i(mode9), .rank_i(rank9), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready9), .data_o(dout_b), .busy_o(busy_b));

  rank_filter #(.DATA_W(16), .N(3), .EARLY_EXIT(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_c), .in_ready_o(in_ready_c),
    .data_i(data_c), .mode_i(mode_c), .rank_i(rank_c), .out_valid_o(out_valid_c),
    .out_ready_i(out_ready_c), .data_o(dout_c), .busy_o(busy_c));

  rank_filter #(.DATA_W(8), .N(25), .EARLY_EXIT(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_d), .in_ready_o(in_ready_d),
    .data_i(data_d), .mode_i(mode_d), .rank_i(rank_d), .out_valid_o(out_valid_d),
    .out_ready_i(out_ready_d), .data_o(dout_d), .busy_o(busy_d));

  // Push one window into instance a or b with out_ready high. Returns the
  // result and the number of edges from accept to out_valid rising (-1 on timeout).
  task automatic run9(input bit use_b, input logic [N9*W8-1:0] win, input logic [1:0] m,
                      input logic [3:0] r, output logic [7:0] res, output int lat);
    int guard;
    @(negedge clk);
    data9 = win; mode9 = m; rank9 = r; out_ready9 = 1'b1;
    if (use_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    guard = 0;
    while (!(use_b ? in_ready_b : in_ready_a) && guard < 100) begin
      @(negedge clk); guard++;
    end
    @(negedge clk);
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    lat = 0;
    while (!(use_b ? out_valid_b : out_valid_a) && lat < 100) begin
      @(negedge clk); lat++;
    end
    if (lat >= 100) lat = -1;
    res = use_b ? dout_b : dout_a;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready_a !== 1'b1 || busy_a !== 1'b0 || out_valid_a !== 1'b0 || dout_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_a: ready=%b busy=%b valid=%b data=%0d, want 1 0 0 0",
               in_ready_a, busy_a, out_valid_a, dout_a);
    end
    checks++;
    if (in_ready_b !== 1'b1 || busy_b !== 1'b0 || out_valid_b !== 1'b0 || dout_b !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: ready=%b busy=%b valid=%b data=%0d, want 1 0 0 0",
               in_ready_b, busy_b, out_valid_b, dout_b);
    end
    checks++;
    if (in_ready_c !== 1'b1 || out_valid_c !== 1'b0 || dout_c !== 16'd0 ||
        in_ready_d !== 1'b1 || out_valid_d !== 1'b0 || dout_d !== 8'd0) begin
      errors++;
      $display("FAIL reset_cd: ready_c=%b valid_c=%b data_c=%0d ready_d=%b valid_d=%b data_d=%0d",
               in_ready_c, out_valid_c, dout_c, in_ready_d, out_valid_d, dout_d);
    end
  endtask

  task automatic test_reversed_no_exit();
    logic [N9*W8-1:0] w;
    logic [7:0] res;
    int lat;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(9 - k);
    run9(1'b0, w, 2'b00, 4'd0, res, lat);
    checks++;
    if (res !== 8'd5) begin errors++; $display("FAIL reversed_median: got %0d want 5", res); end
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL reversed_latency: got %0d want 10", lat); end
    @(negedge clk);
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reversed_return_idle: ready=%b valid=%b want 1 0", in_ready_a, out_valid_a);
    end
  endtask

  task automatic test_sorted_early_exit();
    logic [N9*W8-1:0] w;
    logic [7:0] res;
    int lat;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(k + 1);
    run9(1'b1, w, 2'b00, 4'd0, res, lat);
    checks++;
    if (res !== 8'd5) begin errors++; $display("FAIL sorted_median: got %0d want 5", res); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sorted_latency: got %0d want 3", lat); end
  endtask

  task automatic test_mode_sweep();
    int unsigned v[9]   = '{200, 3, 3, 255, 0, 17, 17, 17, 90};
    logic [1:0]  md[6]  = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [3:0]  rk[6]  = '{4'd0, 4'd0, 4'd4, 4'd1, 4'd12, 4'd0};
    logic [7:0]  ex[6]  = '{8'd0, 8'd255, 8'd17, 8'd3, 8'd255, 8'd17};
    logic [N9*W8-1:0] w;
    logic [7:0] res;
    int lat;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v[k]);
    for (int t = 0; t < 6; t++) begin
      run9(1'b1, w, md[t], rk[t], res, lat);
      checks++;
      if (res !== ex[t] || lat < 0) begin
        errors++;
        $display("FAIL mode_sweep[%0d] mode=%b rank=%0d: got %0d want %0d (lat %0d)",
                 t, md[t], rk[t], res, ex[t], lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N9*W8-1:0] w1, w2;
    int guard;
    bit ok;
    for (int k = 0; k < 9; k++) begin
      w1[k*8 +: 8] = 8'(9 - k);
      w2[k*8 +: 8] = 8'(50 + k);
    end
    @(negedge clk);
    data9 = w1; mode9 = 2'b00; out_ready9 = 1'b0; in_valid_b = 1'b1;
    @(negedge clk);
    data9 = w2;  // pending window held on the input throughout
    guard = 0;
    while (!out_valid_b && guard < 100) begin @(negedge clk); guard++; end
    checks++;
    if (out_valid_b !== 1'b1 || dout_b !== 8'd5) begin
      errors++;
      $display("FAIL bp_first_result: valid=%b data=%0d want 1 5", out_valid_b, dout_b);
    end
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid_b !== 1'b1 || dout_b !== 8'd5 || in_ready_b !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=%0d ready=%b want 1 5 0", out_valid_b, dout_b, in_ready_b);
    end
    out_ready9 = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || dout_b !== 8'd5) begin
      errors++;
      $display("FAIL bp_release: ready=%b valid=%b data=%0d want 1 0 5", in_ready_b, out_valid_b, dout_b);
    end
    @(negedge clk);
    in_valid_b = 1'b0;
    checks++;
    if (busy_b !== 1'b1 || in_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL bp_pending_capture: busy=%b ready=%b want 1 0", busy_b, in_ready_b);
    end
    guard = 0;
    while (!out_valid_b && guard < 100) begin @(negedge clk); guard++; end
    checks++;
    if (out_valid_b !== 1'b1 || dout_b !== 8'd54) begin
      errors++;
      $display("FAIL bp_pending_result: valid=%b data=%0d want 1 54", out_valid_b, dout_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sort();
    logic [N9*W8-1:0] w;
    logic [7:0] res;
    int lat;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(9 - k);
    @(negedge clk);
    data9 = w; mode9 = 2'b00; out_ready9 = 1'b1; in_valid_b = 1'b1;
    @(negedge clk);  // accept edge passed
    in_valid_b = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy_b !== 1'b0 || out_valid_b !== 1'b0 || dout_b !== 8'd0 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b data=%0d ready=%b want 0 0 0 1",
               busy_b, out_valid_b, dout_b, in_ready_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = (k == 8) ? 8'd4 : 8'd5;
    run9(1'b1, w, 2'b00, 4'd0, res, lat);
    checks++;
    if (res !== 8'd5 || lat < 0) begin
      errors++;
      $display("FAIL after_reset_median: got %0d want 5 (lat %0d)", res, lat);
    end
  endtask

  task automatic test_n3_wide();
    logic [1:0]  md[3] = '{2'b00, 2'b01, 2'b10};
    logic [15:0] ex[3] = '{16'h8000, 16'h0000, 16'hFFFF};
    int guard;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      data_c = {16'h8000, 16'h0000, 16'hFFFF};
      mode_c = md[t]; rank_c = 2'd0; out_ready_c = 1'b1; in_valid_c = 1'b1;
      @(negedge clk);
      in_valid_c = 1'b0;
      guard = 0;
      while (!out_valid_c && guard < 50) begin @(negedge clk); guard++; end
      checks++;
      if (out_valid_c !== 1'b1 || dout_c !== ex[t]) begin
        errors++;
        $display("FAIL n3[%0d] mode=%b: valid=%b got %h want %h", t, md[t], out_valid_c, dout_c, ex[t]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_n25_random();
    int unsigned v[25];
    int unsigned tmp;
    int unsigned idx;
    logic [7:0] expv;
    int guard;
    int stall;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 25; k++)
        v[k] = (n % 3 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      @(negedge clk);
      for (int k = 0; k < 25; k++) data_d[k*8 +: 8] = 8'(v[k]);
      mode_d = 2'($urandom_range(0, 3));
      rank_d = 5'($urandom_range(0, 31));
      out_ready_d = 1'b0;
      in_valid_d = 1'b1;
      // reference: bubble sort then select
      for (int i = 0; i < 25; i++)
        for (int j = 0; j < 24 - i; j++)
          if (v[j] > v[j+1]) begin tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp; end
      case (mode_d)
        2'b00:   idx = 12;
        2'b01:   idx = 0;
        2'b10:   idx = 24;
        default: idx = (rank_d > 5'd24) ? 24 : int'(rank_d);
      endcase
      expv = 8'(v[idx]);
      @(negedge clk);
      in_valid_d = 1'b0;
      guard = 0;
      while (!out_valid_d && guard < 100) begin @(negedge clk); guard++; end
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      checks++;
      if (out_valid_d !== 1'b1 || dout_d !== expv) begin
        errors++;
        $display("FAIL n25[%0d] mode=%b rank=%0d: valid=%b got %0d want %0d",
                 n, mode_d, rank_d, out_valid_d, dout_d, expv);
        if (guard >= 100) break;
      end
      out_ready_d = 1'b1;
      @(negedge clk);
      out_ready_d = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; data9 = '0; mode9 = 2'b00; rank9 = '0; out_ready9 = 1'b1;
    in_valid_c = 1'b0; data_c = '0; mode_c = 2'b00; rank_c = '0; out_ready_c = 1'b1;
    in_valid_d = 1'b0; data_d = '0; mode_d = 2'b00; rank_d = '0; out_ready_d = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_reversed_no_exit();
    test_sorted_early_exit();
    test_mode_sweep();
    test_backpressure();
    test_reset_mid_sort();
    test_n3_wide();
    test_n25_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
